// File: rtl/multiplay_mouse_sched.sv
// Multiplay mouse motion scheduler: saturating per-axis accumulators drained in clamped chunks by CPU reads.
// Optional build macro MULTIPLAY_STICKY_BTN_EN latches button presses between addr-0 polls.
module multiplay_mouse_sched #(
   parameter int ACC_W = 12
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [24:0] ps2_mouse,
   input  logic        sel,
   input  logic [2:0]  addr,
   output logic [7:0]  dout
);

   localparam int SUM_W = ACC_W + 2;
   localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W-1)) - 1);
   localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;
   localparam logic signed [ACC_W-1:0] CH_MAX  = ACC_W'(7);
   localparam logic signed [ACC_W-1:0] CH_MIN  = ACC_W'(-8);

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
      if (v > ACC_MAX)      return ACC_W'(ACC_MAX);
      else if (v < ACC_MIN) return ACC_W'(ACC_MIN);
      else                  return ACC_W'(v);
   endfunction

   function automatic logic signed [7:0] clamp_chunk(input logic signed [ACC_W-1:0] a);
      if (a > CH_MAX)      return 8'sd7;
      else if (a < CH_MIN) return -8'sd8;
      else                 return 8'(a);
   endfunction

   logic                    old_status, old_sel, armed;
   logic                    packet, strobe, rd_x, rd_y;
   logic signed [ACC_W-1:0] acc_x, acc_y;
   logic signed [7:0]       chunk_x, chunk_y;
   logic signed [SUM_W-1:0] dx_ext, dy_ext, sum_x, sum_y;
   logic [2:0]              btn_live, btn_rd;
   logic [7:0]              dout_nxt;
   logic                    unused_ps2;

   assign unused_ps2 = &{1'b0, ps2_mouse[7:6], ps2_mouse[3]};

   assign packet   = ps2_mouse[24] ^ old_status;
   // armed stays low after a reset taken with sel high, so that held select cannot strobe
   assign strobe   = sel & ~old_sel & armed;
   assign rd_x     = strobe && (addr == 3'd2);
   assign rd_y     = strobe && (addr == 3'd3);
   assign btn_live = ps2_mouse[2:0];

   assign dx_ext  = SUM_W'($signed({ps2_mouse[4], ps2_mouse[15:8]}));
   assign dy_ext  = -SUM_W'($signed({ps2_mouse[5], ps2_mouse[23:16]}));
   assign chunk_x = clamp_chunk(acc_x);
   assign chunk_y = clamp_chunk(acc_y);

   // chunk comes from the pre-update value, so a same-cycle packet and read both land exactly once
   always_comb begin
      sum_x = SUM_W'(acc_x);
      sum_y = SUM_W'(acc_y);
      if (rd_x)   sum_x = sum_x - SUM_W'(chunk_x);
      if (rd_y)   sum_y = sum_y - SUM_W'(chunk_y);
      if (packet) sum_x = sum_x + dx_ext;
      if (packet) sum_y = sum_y + dy_ext;
   end

`ifdef MULTIPLAY_STICKY_BTN_EN
   logic [2:0] btn_latch;

   assign btn_rd = btn_latch | btn_live;

   always_ff @(posedge clk_sys) begin
      if (reset)
         btn_latch <= 3'b000;
      else if (strobe && (addr == 3'd0))
         btn_latch <= btn_live;
      else if (packet)
         btn_latch <= btn_latch | btn_live;
   end
`else
   assign btn_rd = btn_live;
`endif

   always_comb begin
      dout_nxt = dout;
      if (!sel)
         dout_nxt = 8'hFF;
      else if (strobe) begin
         case (addr)
            3'd0:    dout_nxt = {1'b0, btn_rd, 4'b0000};
            3'd2:    dout_nxt = chunk_x;
            3'd3:    dout_nxt = chunk_y;
            default: dout_nxt = 8'hFF;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      old_status <= ps2_mouse[24];
      if (reset) begin
         old_sel <= 1'b0;
         armed   <= ~sel;
         acc_x   <= '0;
         acc_y   <= '0;
         dout    <= 8'hFF;
      end else begin
         old_sel <= sel;
         armed   <= armed | ~sel;
         acc_x   <= sat_acc(sum_x);
         acc_y   <= sat_acc(sum_y);
         dout    <= dout_nxt;
      end
   end

endmodule

// File: doc/multiplay_mouse_sched.md
# multiplay_mouse_sched

Motion scheduler for the Multiplay mouse port. It accumulates PS/2 mouse packets into saturating per-axis accumulators and serves CPU register reads. Each X/Y read returns one clamped 4-bit-range chunk and subtracts that chunk from the accumulator, so fast motion spread across several polls is not lost. It sits between the HPS PS/2 mouse stream and the Multiplay I/O decode, and drives the port read data directly.

## Interface
Parameters:
- ACC_W, 12, accumulator width in bits (signed); legal range 8..16

Ports:
- clk_sys  in  1  system clock; reset is synchronous, active-high, sampled on clk_sys
- reset  in  1  synchronous active-high reset
- ps2_mouse  in  25  [24] packet toggle, [15:8] dX, [23:16] dY, [4] X sign, [5] Y sign, [2:0] buttons L/R/M
- sel  in  1  port select from I/O decode; its rising edge is the read strobe
- addr  in  3  register address, sampled on the strobe cycle
- dout  out  8  read data; 8'hFF while not selected

## Operation
- Packet detect: a packet arrives when ps2_mouse[24] differs from its registered copy (old_status).
- Packet deltas, 9-bit signed:
  - dx = {ps2_mouse[4], ps2_mouse[15:8]}
  - dy = -{ps2_mouse[5], ps2_mouse[23:16]} (Y is inverted; port convention is down-positive)
- Accumulators acc_x and acc_y are ACC_W signed values.
  - On a packet: acc ← sat(acc + d).
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Intermediate sums use ACC_W+2 bits.
- Read strobe is ~old_sel & sel. On the strobe, decode addr:
  - 0: dout ← {1'b0, btn[2:0], 4'b0000}
  - 2: chunk = clamp(acc_x, -8, 7), sign-extended to 8 bits; dout ← chunk; acc_x ← acc_x - chunk
  - 3: same as addr 2, using acc_y
  - other addresses: dout ← 8'hFF; no state change
- Packet and read of the same axis in the same cycle:
  - acc ← sat(acc - chunk + d).
  - chunk is computed from the pre-update acc.
  - No packet is lost and no chunk is double-counted.
- Packet with a read of the other axis or of buttons: both take effect independently.
- Deselect: whenever sel=0, dout ← 8'hFF. This takes priority over a stale value.
- Zero motion: a read with acc=0 returns 8'h00 and acc stays 0.

## Timing
- Reset values:
  - dout = 8'hFF
  - acc_x = acc_y = 0
  - btn latch = 0
  - old_sel = 0
  - old_status ← ps2_mouse[24], so no spurious packet is seen after reset
- Reset mid-read: reset wins. dout = 8'hFF and accumulators clear. A sel still held high after reset does not produce a strobe until sel falls and rises again.
- Read latency: dout is valid from the first clk_sys edge after the cycle in which sel is first sampled high. It is held while sel stays high.
- A held-high sel produces exactly one strobe; accumulators are decremented once per strobe.
- Packet-to-accumulator latency: the accumulator reflects the packet 1 cycle after the toggle is first sampled.
- Back-to-back packets on consecutive cycles are each accumulated. There is no throughput limit.
- Draining a large move: N reads of +7 for large positive acc. Example: acc=+20 returns 7, 7, 6, then 0.

## Configuration
- MULTIPLAY_STICKY_BTN_EN defined:
  - btn latch ← btn latch | ps2_mouse[2:0] on every packet.
  - An addr-0 read returns latch | live buttons, then reloads the latch with the live buttons.
  - A press and release between two polls is reported once.
- Not defined: addr 0 returns the live ps2_mouse[2:0] only. The latch is not implemented.

## Test plan
- Reset, then read addr 2 and 3 → dout=8'h00 each. With sel low → dout=8'hFF.
- Packet dX=+20, then three X reads → 8'h07, 8'h07, 8'h06; fourth read → 8'h00.
- Packet dY=+5, then Y read → 8'hFB (-5, inverted). Packet dX=-100, then X read → 8'hF8 and acc_x=-92.
- Packet dX=+3 in the same cycle as an X strobe with acc_x=+10 → dout=8'h07, acc_x=+6.
- 20 packets of dX=+255 with ACC_W=12 → acc_x saturates at +2047 with no wrap. A subsequent read → 8'h07, acc_x=+2040.
- Sticky build: packet with buttons=3'b001, then a packet with buttons=0, then addr-0 read → 8'h10. Second read → 8'h00. Non-sticky build: first read → 8'h00.
